// File: rtl/noc_inject_arbiter.sv
// noc_inject_arbiter: round-robin arbiter feeding one router injection port
// with a held packet that is delivered or dropped after a wait timeout.
module noc_inject_arbiter #(
  parameter int NREQ    = 4,
  parameter int PKT_W   = 9,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*PKT_W-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [PKT_W-1:0]      inj_data,
  input  logic                  inj_ready,
  output logic [1:0]            grant_id,
  output logic                  busy,
  output logic [15:0]           sent_cnt,
  output logic [15:0]           drop_cnt
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [1:0] ptr, g, idx;
  logic found;
  logic [7:0] wait_cnt;
  logic [PKT_W-1:0] pkt;
  always_comb begin
    g = ptr;
    found = 1'b0;
    idx = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req_valid[idx]) begin
        g = idx;
        found = 1'b1;
      end
    end
  end
  assign pkt = req_data[32'(g)*PKT_W +: PKT_W];
  assign req_ready = (state == IDLE && found) ? ({{(NREQ-1){1'b0}}, 1'b1} << g) : '0;
  assign busy = (state == SEND);
  // inj_data is the hold register itself; clearing it on exit marks "no packet"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'(NREQ-1);
      inj_data <= '0;
      grant_id <= '0;
      wait_cnt <= '0;
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        inj_data <= pkt | {1'b1, {(PKT_W-1){1'b0}}};
        grant_id <= g;
        ptr      <= g;
        wait_cnt <= '0;
        state    <= SEND;
      end
    end else if (inj_ready) begin
      sent_cnt <= sent_cnt + 16'(sent_cnt != 16'hFFFF);
      inj_data <= '0;
      state    <= IDLE;
    end else if (wait_cnt == 8'(TIMEOUT-1)) begin
      drop_cnt <= drop_cnt + 16'(drop_cnt != 16'hFFFF);
      inj_data <= '0;
      state    <= IDLE;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_noc_inject_arbiter.sv
// tb_noc_inject_arbiter: directed stimulus, transaction-level model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_noc_inject_arbiter;
  localparam int NREQ = 4, PKT_W = 9, TIMEOUT = 16;
  logic clk = 0, rst_n;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*PKT_W-1:0] req_data;
  logic [PKT_W-1:0] inj_data;
  logic inj_ready, busy;
  logic [1:0] grant_id;
  logic [15:0] sent_cnt, drop_cnt;
  int checks = 0, failures = 0;
  logic chk_en, sat_load;

  noc_inject_arbiter #(.NREQ(NREQ), .PKT_W(PKT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .inj_data(inj_data), .inj_ready(inj_ready),
    .grant_id(grant_id), .busy(busy), .sent_cnt(sent_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a held packet owned by a winner, a pointer to last winner, counters.
  logic m_busy;
  logic [PKT_W-1:0] m_hold;
  int m_gid, m_ptr, m_wait, m_sent, m_drop;

  function automatic int pick(input int p, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_hold <= 0; m_gid <= 0; m_ptr <= NREQ-1;
      m_wait <= 0; m_sent <= 0; m_drop <= 0;
    end else if (sat_load) begin
      m_sent <= 16'hFFFE;
    end else if (!m_busy) begin
      if (req_valid != 0) begin
        m_busy <= 1;
        m_gid  <= pick(m_ptr, req_valid);
        m_ptr  <= pick(m_ptr, req_valid);
        m_hold <= req_data[pick(m_ptr, req_valid)*PKT_W +: PKT_W] | 9'h100;
        m_wait <= 1;
      end
    end else if (inj_ready) begin
      m_busy <= 0;
      m_sent <= (m_sent < 65535) ? m_sent + 1 : m_sent;
    end else if (m_wait == TIMEOUT) begin
      m_busy <= 0;
      m_drop <= (m_drop < 65535) ? m_drop + 1 : m_drop;
    end else begin
      m_wait <= m_wait + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("model req_ready", 32'(req_ready),
          (!m_busy && req_valid != 0) ? 32'(1) << pick(m_ptr, req_valid) : 32'd0);
      chk("model inj_data", 32'(inj_data), m_busy ? 32'(m_hold) : 32'd0);
      chk("model busy", 32'(busy), 32'(m_busy));
      if (m_busy) chk("model grant_id", 32'(grant_id), 32'(m_gid));
      chk("model sent_cnt", 32'(sent_cnt), 32'(m_sent));
      chk("model drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    rst_n = 1;
  endtask

  int n;
  logic [PKT_W-1:0] first;

  initial begin
    rst_n = 0; req_valid = 0; req_data = 0; inj_ready = 0; chk_en = 1; sat_load = 0;
    #3;
    chk("reset inj_data", 32'(inj_data), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset grant_id", 32'(grant_id), 0);
    chk("reset sent_cnt", 32'(sent_cnt), 0);
    chk("reset drop_cnt", 32'(drop_cnt), 0);
    tick();
    rst_n = 1;

    // Single requester 2
    req_valid = 4'b0100; req_data = 36'h0A5 << 18; inj_ready = 1;
    #1 chk("single req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 0;
    chk("single inj_data", 32'(inj_data), 32'h1A5);
    chk("single grant_id", 32'(grant_id), 2);
    chk("single busy", 32'(busy), 1);
    tick();
    chk("single idle", 32'(busy), 0);
    chk("single inj_zero", 32'(inj_data), 0);
    chk("single sent", 32'(sent_cnt), 1);

    // All requesting, always ready: order 0,1,2,3,0,...
    do_reset();
    req_valid = 4'b1111; inj_ready = 1;
    req_data = {9'h033, 9'h022, 9'h011, 9'h000};
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k % 2 == 0) chk("rr grant order", 32'(grant_id), 32'((k / 2) % 4));
      chk("rr busy alternates", 32'(busy), 32'(k % 2 == 0));
    end
    chk("rr sent 8", 32'(sent_cnt), 8);
    req_valid = 0;

    // Timeout drop
    do_reset();
    req_valid = 4'b0001; inj_ready = 0; req_data = 36'h07E;
    tick();
    req_valid = 0;
    first = inj_data;
    n = 0;
    while (busy && inj_data == first && n < 40) begin
      n++;
      tick();
    end
    chk("timeout send cycles", n, 16);
    chk("timeout held value", 32'(first), 32'h17E);
    chk("timeout inj_zero", 32'(inj_data), 0);
    chk("timeout drop", 32'(drop_cnt), 1);
    chk("timeout sent", 32'(sent_cnt), 0);

    // Ready in the final SEND cycle: delivery wins
    do_reset();
    req_valid = 4'b0001;
    tick();
    req_valid = 0;
    repeat (15) tick();
    inj_ready = 1;
    tick();
    chk("late ready sent", 32'(sent_cnt), 1);
    chk("late ready drop", 32'(drop_cnt), 0);
    chk("late ready idle", 32'(busy), 0);

    // Reset mid-SEND
    do_reset();
    req_valid = 4'b0001; inj_ready = 1;
    tick(); tick();
    req_valid = 4'b0010; inj_ready = 0;
    tick();
    req_valid = 0;
    tick(); tick();
    rst_n = 0;
    #1;
    chk("midreset inj_data", 32'(inj_data), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset sent", 32'(sent_cnt), 0);
    chk("midreset drop", 32'(drop_cnt), 0);
    rst_n = 1;
    req_valid = 4'b1111; inj_ready = 1;
    tick();
    chk("midreset first grant", 32'(grant_id), 0);
    tick();
    req_valid = 0;
    tick(); tick();

    // Saturation: preload near the limit, then deliver several more
    chk_en = 0; sat_load = 1;
    force dut.sent_cnt = 16'hFFFE;
    tick();
    release dut.sent_cnt;
    sat_load = 0;
    #1 chk_en = 1;
    chk("sat preload", 32'(sent_cnt), 32'hFFFE);
    req_valid = 4'b1111; inj_ready = 1;
    repeat (6) tick();
    chk("sat stays max", 32'(sent_cnt), 32'hFFFF);
    req_valid = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
